lut_seq: RTL
============

LUT_SEQ -- requirements
Module: lut_seq

Interface
REQ-001 Parameter WIDTH, default 8, bit width of each table entry and of dm_o.
REQ-002 Parameter DEPTH, default 32, number of table entries (2..256, not necessarily a power of 2).
REQ-003 Parameter IDX_W, default $clog2(DEPTH), width of every index and pointer port.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write strobe for one table entry.
REQ-007 wr_idx  input  IDX_W  write index.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 rd_en  input  1  indexed read request; also loads the walk pointer.
REQ-010 rd_idx  input  IDX_W  read index.
REQ-011 step  input  1  advance the walk pointer and read the next entry.
REQ-012 dm_o  output  WIDTH  registered lookup result (data memory address).
REQ-013 valid_o  output  1  dm_o updated by the previous cycle's request.
REQ-014 ptr_o  output  IDX_W  current walk pointer.
REQ-015 oob_o  output  1  previous request's index was out of range.

Function
REQ-016 The block SHALL hold DEPTH x WIDTH writable entries in registers.
REQ-017 When wr_en=1 and wr_idx<DEPTH, the entry SHALL be written at the clock edge; wr_idx>=DEPTH SHALL be ignored.
REQ-018 When rd_en=1, the block SHALL load dm_o with entry[rd_idx] and ptr_o with rd_idx, and set valid_o=1, all at the same edge (latency 1 cycle).
REQ-019 When rd_en=0 and step=1, ptr SHALL advance to ptr+1, wrapping from DEPTH-1 to 0; dm_o SHALL load entry[new ptr]; valid_o SHALL be 1.
REQ-020 When rd_en and step are both 1, rd_en SHALL win and step SHALL be ignored.
REQ-021 When neither rd_en nor step is 1, valid_o SHALL be 0; dm_o and ptr_o SHALL hold their values.
REQ-022 A read or step that targets the entry being written in the same cycle SHALL return wr_data (write-through bypass).
REQ-023 rd_en with rd_idx>=DEPTH SHALL load dm_o=0 and set valid_o=1 and oob_o=1, leaving ptr_o unchanged; oob_o SHALL be 0 after every other cycle.
REQ-024 Writes SHALL proceed independently of, and concurrently with, reads and steps.

Reset
REQ-025 When reset=1 at an edge, dm_o=0, valid_o=0, oob_o=0 and ptr_o=0 SHALL be loaded, and the table SHALL be initialised per REQ-027/028.
REQ-026 reset SHALL take priority over wr_en, rd_en and step in the same cycle; those requests SHALL be discarded.

Configuration
REQ-027 With macro LUT_SEQ_PRELOAD_EN defined, reset SHALL load entry[0]=14, entry[1]=20 and entry[2]=127, and all other entries SHALL be 0 (values truncated to WIDTH).
REQ-028 Without LUT_SEQ_PRELOAD_EN, reset SHALL load every entry with 0.

Verification
REQ-029 Preload build: reset, then rd_en with rd_idx=0,1,2,3 on consecutive cycles -> dm_o=14,20,127,0 one cycle after each request, with valid_o=1 each cycle.
REQ-030 Write wr_idx=5, wr_data=8'hA5 together with rd_en, rd_idx=5 in the same cycle -> next cycle dm_o=8'hA5 (bypass); a later read of index 5 also returns 8'hA5.
REQ-031 DEPTH=32: rd_en with rd_idx=30, then step on three consecutive cycles -> ptr_o=31,0,1; dm_o=entry[31],entry[0],entry[1].
REQ-032 DEPTH=20: rd_en with rd_idx=25 -> dm_o=0, valid_o=1, oob_o=1, ptr_o unchanged; wr_en with wr_idx=25 leaves every entry unchanged.
REQ-033 Assert rd_en and step together, rd_idx=7 -> ptr_o=7 and dm_o=entry[7]; then go idle one cycle -> valid_o=0 and dm_o held.
REQ-034 Assert reset while rd_en=1 and wr_en=1 (wr_idx=0, wr_data=8'h55) -> dm_o=0, valid_o=0, ptr_o=0, and entry[0] equals its reset value (14 with the preload macro, 0 without).

Source files
------------

// File: rtl/lut_seq.sv
// Register-based lookup table with indexed read and wrapping sequential walk.
// Define LUT_SEQ_PRELOAD_EN to have reset load entries 0..2 with 14, 20 and 127.
module lut_seq #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             step,
  output logic [WIDTH-1:0] dm_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] ptr_o,
  output logic             oob_o
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dm;
  logic             r_valid;
  logic             r_oob;
  logic [IDX_W-1:0] r_ptr;

  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_tgt;
  logic             w_oob;
  logic             w_go;
  logic [WIDTH-1:0] w_rd;

  // rd_en outranks step; the target entry is muxed out with a same-cycle write bypass
  always_comb begin
    w_ptr_nxt = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    w_oob     = rd_en && (int'(rd_idx) >= DEPTH);
    w_tgt     = rd_en ? rd_idx : w_ptr_nxt;
    w_go      = rd_en | step;
    w_rd      = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_tgt == IDX_W'(i)) w_rd = r_mem[i];
    if (wr_en && (wr_idx == w_tgt)) w_rd = wr_data;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_dm    <= '0;
      r_valid <= 1'b0;
      r_oob   <= 1'b0;
      r_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
`ifdef LUT_SEQ_PRELOAD_EN
        if (i == 0) r_mem[i] <= WIDTH'(14);
        if (i == 1) r_mem[i] <= WIDTH'(20);
        if (i == 2) r_mem[i] <= WIDTH'(127);
`endif
      end
    end else begin
      // out-of-range write indices match no entry and fall away
      for (int i = 0; i < DEPTH; i++)
        if (wr_en && (wr_idx == IDX_W'(i))) r_mem[i] <= wr_data;
      r_valid <= w_go;
      r_oob   <= w_oob;
      if (w_oob) begin
        r_dm <= '0;
      end else if (w_go) begin
        r_dm  <= w_rd;
        r_ptr <= w_tgt;
      end
    end
  end

  assign dm_o    = r_dm;
  assign valid_o = r_valid;
  assign ptr_o   = r_ptr;
  assign oob_o   = r_oob;
endmodule
